avalon_master_arbiter: RTL
==========================

// Module: avalon_master_arbiter
// PURPOSE
//  Shares one fixed-latency Avalon-MM register slave (register adapter) between MASTERS requesters.
//  Round-robin grants one read/write per cycle, stalls losers via waitrequest, and routes each read
//  response back to its issuing master via an in-flight ID pipeline. Sits between masters and adapter.
// PARAMETERS
//  MASTERS      2   number of requesting masters (>=2); IDW = $clog2(MASTERS)
//  BUSWIDTH     32  data width
//  ADDRESSWIDTH 4   word address width of the shared slave
//  LATENCY      1   slave read latency, cycles from accepted read to s_read_valid (>=1)
// PORTS
//  clk             in   1                     clock
//  reset           in   1                     asynchronous, active-high reset
//  m_read          in   MASTERS               per-master read request
//  m_write         in   MASTERS               per-master write request
//  m_address       in   MASTERS*ADDRESSWIDTH  packed addresses, master i at [i*AW +: AW]
//  m_data_in       in   MASTERS*BUSWIDTH      packed write data, master i at [i*BW +: BW]
//  m_waitrequest   out  MASTERS               1 = request not accepted this cycle, hold it
//  m_read_valid    out  MASTERS               read response strobe for master i
//  m_data_out      out  BUSWIDTH              read data, common to all masters, qualify with m_read_valid
//  s_read          out  1                     to slave read
//  s_write         out  1                     to slave write
//  s_address       out  ADDRESSWIDTH          to slave address
//  s_data_in       out  BUSWIDTH              to slave write data
//  s_read_valid    in   1                     from slave read_valid
//  s_data_out      in   BUSWIDTH              from slave read data
//  grant_id        out  IDW                   master granted this cycle (valid when s_read|s_write)
//  protocol_error  out  1                     sticky error flag
// BEHAVIOUR
//  - Request of master i = m_read[i] | m_write[i]. Grant is combinational, same cycle as request.
//  - Round-robin: search starts at priority pointer rr_ptr, wraps MASTERS-1 -> 0; first requester wins.
//  - On a grant to k, rr_ptr <= (k+1) mod MASTERS at next edge; no grant -> rr_ptr unchanged.
//  - Winner: m_waitrequest[k]=0, its read/write/address/data driven onto s_*; the slave never stalls, so
//    the winning transfer is accepted in that cycle.
//  - Losers: m_waitrequest[i]=1 exactly while i requests and is not granted; 0 when not requesting.
//  - No request: s_read=s_write=0, s_address/s_data_in=0, grant_id=0.
//  - m_read[k] & m_write[k] together: forwarded as write only (s_read=0), read dropped, protocol_error<=1.
//  - In-flight pipeline: LATENCY stages of {valid,id}; stage0 loads {s_read,grant_id}, shifts every cycle.
//    Requests are never throttled by it: at most one read enters per cycle, so it cannot overflow.
//  - Response: when s_read_valid=1 and last stage valid, m_read_valid[id]=1 (one-hot),
//    m_data_out=s_data_out (pass-through, 0 added latency). Master sees read data LATENCY cycles
//    after its accepted (non-waitrequest) read cycle.
//  - s_read_valid=1 with last stage invalid, or last stage valid without s_read_valid:
//    protocol_error<=1; spurious response not routed (all m_read_valid=0).
//  - protocol_error: cleared only by reset.
//  - Reset (async, any time): rr_ptr=0, pipeline cleared, protocol_error=0; m_read_valid=0,
//    m_waitrequest follows requests vs. rr_ptr=0. In-flight reads are discarded; slave responses
//    arriving after reset release are flagged as spurious.
//  - Registered state: rr_ptr, ID pipeline, protocol_error. All other outputs combinational.
// TESTING
//  1 MASTERS=2,LATENCY=1: m0 reads addr 3 alone -> s_read=1, waitreq=0; next cycle m_read_valid=2'b01.
//  2 m0,m1 write continuously from reset -> grants alternate 0,1,0,1; each waitreq asserted alternately.
//  3 MASTERS=4,LATENCY=3: m2 read then m0 read back-to-back -> m_read_valid[2] at t+3, [0] at t+4.
//  4 m1 asserts read&write -> s_write=1,s_read=0, protocol_error=1 until reset.
//  5 Reset asserted with two reads in flight -> no m_read_valid; late s_read_valid raises protocol_error.
//  6 Random 3-master traffic -> every accepted read yields one m_read_valid to its issuer; no starvation
//    beyond MASTERS-1 cycles.

Source files
------------

// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter
//   Shares one fixed-latency Avalon-MM register slave between MASTERS requesters.
//   A round-robin arbiter grants one read or write per cycle, combinationally in the
//   request cycle. Losing masters are stalled with waitrequest. Each accepted read
//   pushes the winner's ID into an in-flight pipeline, so the read response is
//   steered back to the master that issued it.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   m_read/m_write    per-master read/write requests
//   m_address         packed word addresses, master i at [i*ADDRESSWIDTH +: ADDRESSWIDTH]
//   m_data_in         packed write data, master i at [i*BUSWIDTH +: BUSWIDTH]
//   m_waitrequest     per-master stall; high while requesting and not granted
//   m_read_valid      one-hot read response strobe
//   m_data_out        shared read data, qualified by m_read_valid
//   s_read/s_write    request to the slave
//   s_address         address to the slave
//   s_data_in         write data to the slave
//   s_read_valid      read response strobe from the slave
//   s_data_out        read data from the slave
//   grant_id          granted master, valid while s_read or s_write is high
//   protocol_error    sticky error flag, cleared only by reset
module avalon_master_arbiter #(
    parameter int unsigned MASTERS      = 2,
    parameter int unsigned BUSWIDTH     = 32,
    parameter int unsigned ADDRESSWIDTH = 4,
    parameter int unsigned LATENCY      = 1,
    localparam int unsigned IDW         = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MASTERS-1:0]               m_read,
    input  logic [MASTERS-1:0]               m_write,
    input  logic [MASTERS*ADDRESSWIDTH-1:0]  m_address,
    input  logic [MASTERS*BUSWIDTH-1:0]      m_data_in,
    output logic [MASTERS-1:0]               m_waitrequest,
    output logic [MASTERS-1:0]               m_read_valid,
    output logic [BUSWIDTH-1:0]              m_data_out,
    output logic                             s_read,
    output logic                             s_write,
    output logic [ADDRESSWIDTH-1:0]          s_address,
    output logic [BUSWIDTH-1:0]              s_data_in,
    input  logic                             s_read_valid,
    input  logic [BUSWIDTH-1:0]              s_data_out,
    output logic [IDW-1:0]                   grant_id,
    output logic                             protocol_error
);

    // Registered state
    logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [LATENCY-1:0]          pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0][IDW-1:0] pipe_id_q, pipe_id_d;
    logic                        prot_err_q, prot_err_d;

    // Arbitration
    logic [MASTERS-1:0] req;
    logic               any_grant;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic               win_rd;
    logic               win_wr;
    logic               rw_conflict;

    // Response path
    logic               last_valid;
    logic [IDW-1:0]     last_id;
    logic               resp_ok;

    // Candidate index (ptr + offset) wrapped into 0..MASTERS-1.
    function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
        return IDW'(v % MASTERS);
    endfunction

    // Round-robin search starting at rr_ptr_q; the first requester found wins.
    always_comb begin
        req       = m_read | m_write;
        any_grant = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 0; off < MASTERS; off++) begin
            cand = wrap_idx(32'(rr_ptr_q) + off);
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Winner mux onto the slave side; everything idles at zero without a grant.
    always_comb begin
        m_waitrequest = req;
        win_rd        = 1'b0;
        win_wr        = 1'b0;
        s_address     = '0;
        s_data_in     = '0;
        for (int i = 0; i < int'(MASTERS); i++) begin
            if (any_grant && (grant_idx == IDW'(i))) begin
                m_waitrequest[i] = 1'b0;
                win_rd           = m_read[i];
                win_wr           = m_write[i];
                s_address        = m_address[i*ADDRESSWIDTH +: ADDRESSWIDTH];
                s_data_in        = m_data_in[i*BUSWIDTH +: BUSWIDTH];
            end
        end
        // Read and write together: the write goes through, the read is dropped.
        s_write     = win_wr;
        s_read      = win_rd & ~win_wr;
        rw_conflict = win_rd & win_wr;
        grant_id    = grant_idx;
    end

    // Pointer moves just past the winner; held when nobody is granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            if (grant_idx == IDW'(MASTERS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // In-flight ID pipeline; one stage per cycle of slave read latency.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_id_d       = '0;
        pipe_valid_d[0] = s_read;
        pipe_id_d[0]    = grant_idx;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_id_d[i]    = pipe_id_q[i-1];
        end
    end

    // Response routing. A response without a matching in-flight read (or a
    // missing response) is not routed and latches the error flag.
    always_comb begin
        last_valid   = pipe_valid_q[LATENCY-1];
        last_id      = pipe_id_q[LATENCY-1];
        resp_ok      = s_read_valid & last_valid;
        m_read_valid = '0;
        for (int i = 0; i < int'(MASTERS); i++) begin
            m_read_valid[i] = resp_ok && (last_id == IDW'(i));
        end
        m_data_out     = s_data_out;
        prot_err_d     = prot_err_q | rw_conflict | (s_read_valid ^ last_valid);
        protocol_error = prot_err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            pipe_valid_q <= '0;
            pipe_id_q    <= '0;
            prot_err_q   <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_id_q    <= pipe_id_d;
            prot_err_q   <= prot_err_d;
        end
    end

endmodule
